// File: rtl/pipe_reg_decode_execute.sv
// Decode->Execute pipeline register with stall hold, flush bubble and valid tracking.
// Optional stall/flush counters are compiled in when PIPE_STATS_EN is defined.
module pipe_reg_decode_execute #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int CTRL_W  = 12,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallE,
  input  logic               FlushE,
  input  logic               ValidD,
  input  logic [CTRL_W-1:0]  CtrlD,
  input  logic [DATA_W-1:0]  RD1D,
  input  logic [DATA_W-1:0]  RD2D,
  input  logic [DATA_W-1:0]  PCD,
  input  logic [DATA_W-1:0]  PCPlus4D,
  input  logic [DATA_W-1:0]  ImmExtD,
  input  logic [REG_W-1:0]   RdD,
  input  logic [REG_W-1:0]   Rs1D,
  input  logic [REG_W-1:0]   Rs2D,
  output logic               ValidE,
  output logic [CTRL_W-1:0]  CtrlE,
  output logic [DATA_W-1:0]  RD1E,
  output logic [DATA_W-1:0]  RD2E,
  output logic [DATA_W-1:0]  PCE,
  output logic [DATA_W-1:0]  PCPlus4E,
  output logic [DATA_W-1:0]  ImmExtE,
  output logic [REG_W-1:0]   RdE,
  output logic [REG_W-1:0]   Rs1E,
  output logic [REG_W-1:0]   Rs2E,
  output logic [COUNT_W-1:0] StallCntE,
  output logic [COUNT_W-1:0] FlushCntE
);

  typedef struct packed {
    logic              valid;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] imm;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
  } id_ex_t;

  id_ex_t e_d, e_q;

  // Flush beats stall; an invalid decode slot still carries data but no control.
  always_comb begin
    e_d = e_q;
    if (FlushE) begin
      e_d = '0;
    end else if (!StallE) begin
      e_d.valid    = ValidD;
      e_d.ctrl     = ValidD ? CtrlD : '0;
      e_d.rd1      = RD1D;
      e_d.rd2      = RD2D;
      e_d.pc       = PCD;
      e_d.pc_plus4 = PCPlus4D;
      e_d.imm      = ImmExtD;
      e_d.rd       = RdD;
      e_d.rs1      = Rs1D;
      e_d.rs2      = Rs2D;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) e_q <= '0;
    else     e_q <= e_d;
  end

  assign ValidE   = e_q.valid;
  assign CtrlE    = e_q.ctrl;
  assign RD1E     = e_q.rd1;
  assign RD2E     = e_q.rd2;
  assign PCE      = e_q.pc;
  assign PCPlus4E = e_q.pc_plus4;
  assign ImmExtE  = e_q.imm;
  assign RdE      = e_q.rd;
  assign Rs1E     = e_q.rs1;
  assign Rs2E     = e_q.rs2;

`ifdef PIPE_STATS_EN
  logic [COUNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [COUNT_W-1:0] flush_cnt_d, flush_cnt_q;

  // Saturating counters: stop at all-ones rather than wrap.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (FlushE && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + 1'b1;
    if (StallE && !FlushE && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCntE = stall_cnt_q;
  assign FlushCntE = flush_cnt_q;
`else
  assign StallCntE = {COUNT_W{1'b0}};
  assign FlushCntE = {COUNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_reg_decode_execute.sv
// Self-checking bench for pipe_reg_decode_execute.
// Expected E-state is queued at drive time and compared after each clock edge.
module tb_pipe_reg_decode_execute;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 12;
  localparam int NW = 4;

  logic          clk = 1'b0;
  logic          rst, StallE, FlushE, ValidD;
  logic [CW-1:0] CtrlD;
  logic [DW-1:0] RD1D, RD2D, PCD, PCPlus4D, ImmExtD;
  logic [RW-1:0] RdD, Rs1D, Rs2D;
  logic          ValidE;
  logic [CW-1:0] CtrlE;
  logic [DW-1:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
  logic [RW-1:0] RdE, Rs1E, Rs2E;
  logic [NW-1:0] StallCntE, FlushCntE;

  pipe_reg_decode_execute #(
    .DATA_W(DW), .REG_W(RW), .CTRL_W(CW), .COUNT_W(NW)
  ) dut (
    .clk(clk), .rst(rst), .StallE(StallE), .FlushE(FlushE),
    .ValidD(ValidD), .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D),
    .PCD(PCD), .PCPlus4D(PCPlus4D), .ImmExtD(ImmExtD),
    .RdD(RdD), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .ValidE(ValidE), .CtrlE(CtrlE), .RD1E(RD1E), .RD2E(RD2E),
    .PCE(PCE), .PCPlus4E(PCPlus4E), .ImmExtE(ImmExtE),
    .RdE(RdE), .Rs1E(Rs1E), .Rs2E(Rs2E),
    .StallCntE(StallCntE), .FlushCntE(FlushCntE)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          v;
    logic [CW-1:0] c;
    logic [DW-1:0] rd1, rd2, pc, pc4, imm;
    logic [RW-1:0] rd, rs1, rs2;
    logic [NW-1:0] sc, fc;
  } st_t;

  st_t m = '0;
  st_t sb[$];
  int  n_chk = 0;
  int  n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NW-1:0] sat_inc(input logic [NW-1:0] x);
    return (x == {NW{1'b1}}) ? x : x + 1'b1;
  endfunction

  task automatic cyc();
    st_t n, e;
    n = m;
    if (rst) begin
      n = '0;
    end else if (FlushE) begin
      n    = '0;
      n.sc = m.sc;
      n.fc = sat_inc(m.fc);
    end else if (StallE) begin
      n.sc = sat_inc(m.sc);
    end else begin
      n.v   = ValidD;
      n.c   = ValidD ? CtrlD : '0;
      n.rd1 = RD1D;  n.rd2 = RD2D;
      n.pc  = PCD;   n.pc4 = PCPlus4D;
      n.imm = ImmExtD;
      n.rd  = RdD;   n.rs1 = Rs1D;  n.rs2 = Rs2D;
    end
`ifndef PIPE_STATS_EN
    n.sc = '0;
    n.fc = '0;
`endif
    m = n;
    sb.push_back(n);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("valid", 64'(ValidE), 64'(e.v));
    check_eq("ctrl", 64'(CtrlE), 64'(e.c));
    check_eq("rd1", 64'(RD1E), 64'(e.rd1));
    check_eq("rd2", 64'(RD2E), 64'(e.rd2));
    check_eq("pc", 64'(PCE), 64'(e.pc));
    check_eq("pc4", 64'(PCPlus4E), 64'(e.pc4));
    check_eq("imm", 64'(ImmExtE), 64'(e.imm));
    check_eq("rd", 64'(RdE), 64'(e.rd));
    check_eq("rs1", 64'(Rs1E), 64'(e.rs1));
    check_eq("rs2", 64'(Rs2E), 64'(e.rs2));
    check_eq("stallcnt", 64'(StallCntE), 64'(e.sc));
    check_eq("flushcnt", 64'(FlushCntE), 64'(e.fc));
  endtask

  task automatic rnd_in();
    ValidD   = 1'($urandom);
    CtrlD    = CW'($urandom);
    RD1D     = $urandom;
    RD2D     = $urandom;
    PCD      = $urandom;
    PCPlus4D = $urandom;
    ImmExtD  = $urandom;
    RdD      = RW'($urandom);
    Rs1D     = RW'($urandom);
    Rs2D     = RW'($urandom);
  endtask

  logic [NW-1:0] exp_sat, exp_f3;

  initial begin
`ifdef PIPE_STATS_EN
    exp_sat = 4'd15;
    exp_f3  = 4'd3;
`else
    exp_sat = 4'd0;
    exp_f3  = 4'd0;
`endif
    rst = 1'b1; StallE = 1'b0; FlushE = 1'b0;
    rnd_in();
    #1;
    // Reset with random inputs
    repeat (2) begin rnd_in(); StallE = 1'($urandom); cyc(); end
    check_eq("rst_valid", 64'(ValidE), 64'd0);
    check_eq("rst_pc", 64'(PCE), 64'd0);
    rst = 1'b0; StallE = 1'b0; FlushE = 1'b0;
    rnd_in(); ValidD = 1'b1; PCD = 32'h100;
    cyc();
    check_eq("load_pc100", 64'(PCE), 64'h100);

    // Plain load
    rnd_in(); ValidD = 1'b1; CtrlD = 12'hA5C; RD1D = 32'hDEADBEEF; RdD = 5'd7;
    cyc();
    check_eq("ld_ctrl", 64'(CtrlE), 64'hA5C);
    check_eq("ld_rd1", 64'(RD1E), 64'hDEADBEEF);
    check_eq("ld_rd", 64'(RdE), 64'd7);
    check_eq("ld_valid", 64'(ValidE), 64'd1);

    // Stall holds
    rnd_in(); ValidD = 1'b1; PCD = 32'h200;
    cyc();
    StallE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rnd_in(); PCD = 32'h300 + 32'(i);
      cyc();
      check_eq("stall_pc", 64'(PCE), 64'h200);
    end
    StallE = 1'b0; rnd_in(); PCD = 32'h400;
    cyc();
    check_eq("unstall_pc", 64'(PCE), 64'h400);

    // Stall and flush together
    StallE = 1'b1; FlushE = 1'b1; rnd_in(); ValidD = 1'b1;
    cyc();
    check_eq("sf_valid", 64'(ValidE), 64'd0);
    check_eq("sf_ctrl", 64'(CtrlE), 64'd0);
    check_eq("sf_rd1", 64'(RD1E), 64'd0);
    StallE = 1'b0; FlushE = 1'b0;

    // Invalid decode slot
    rnd_in(); ValidD = 1'b0; CtrlD = 12'hFFF; RD2D = 32'h55;
    cyc();
    check_eq("bub_ctrl", 64'(CtrlE), 64'd0);
    check_eq("bub_valid", 64'(ValidE), 64'd0);
    check_eq("bub_rd2", 64'(RD2E), 64'h55);

    // Counters
    rst = 1'b1; cyc(); rst = 1'b0;
    StallE = 1'b1;
    repeat (20) begin rnd_in(); cyc(); end
    check_eq("stall_sat", 64'(StallCntE), 64'(exp_sat));
    StallE = 1'b0; FlushE = 1'b1;
    repeat (3) begin rnd_in(); cyc(); end
    check_eq("flush3", 64'(FlushCntE), 64'(exp_f3));
    FlushE = 1'b0; rst = 1'b1;
    cyc();
    check_eq("cnt_rst_s", 64'(StallCntE), 64'd0);
    check_eq("cnt_rst_f", 64'(FlushCntE), 64'd0);
    rst = 1'b0;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      rnd_in();
      rst    = ($urandom_range(39) == 0);
      FlushE = ($urandom_range(5) == 0);
      StallE = ($urandom_range(3) == 0);
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end
endmodule
